mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store sequencer that sits directly upstream of DataMemory and owns its ReadMem/WriteMem/data_addr/DataIn/DataOut pins.
- Accepts one byte or 16-bit (two-byte, little-endian) load/store request from the execute stage using a valid/ready handshake.
- Splits wide accesses into two byte accesses and returns a single response.
- Holds req_ready low while busy so the pipeline stalls.

Parameters:
ADDR_W, 8, width of data_addr and req_addr
DATA_W, 8, DataMemory word width; wide ops are 2*DATA_W
READ_LATENCY, 0, extra cycles ReadMem/data_addr are held before DataOut is sampled (legal values 0..3)

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit idle and able to accept
req_write  input  1  1 = store, 0 = load
req_wide  input  1  1 = 16-bit access at addr, addr+1
req_addr  input  ADDR_W  byte address
req_wdata  input  2*DATA_W  store data; narrow uses [7:0]
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  2*DATA_W  load result, valid with resp_valid
ReadMem  output  1  to DataMemory
WriteMem  output  1  to DataMemory
data_addr  output  ADDR_W  to DataMemory
DataIn  output  DATA_W  to DataMemory
DataOut  input  DATA_W  from DataMemory, combinational read data

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - req_ready = 1.
  - resp_valid, ReadMem, WriteMem = 0.
  - data_addr, DataIn, resp_rdata = 0.
  - Internal latches cleared.
- States: IDLE, ACC_LO, ACC_HI, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch write, wide, addr, wdata; go to ACC_LO.
  - req_valid while req_ready = 0 is ignored; there is no queue. The requester must hold the request.
- ACC_LO:
  - data_addr = addr; DataIn = wdata[7:0] on stores.
  - WriteMem = write; ReadMem = !write.
  - Stores last exactly 1 cycle.
  - Loads last 1 + READ_LATENCY cycles, with address and ReadMem held constant. DataOut is captured into lo at the final edge.
  - Next state: ACC_HI if wide, else RESP.
- ACC_HI:
  - Same as ACC_LO, with data_addr = addr + 1 (wraps 0xFF -> 0x00, mod 2^ADDR_W).
  - DataIn = wdata[15:8]; load result captured into hi.
  - Next state: RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle.
  - resp_rdata = {hi, lo} for a wide load, {8'h00, lo} for a narrow load, 0 for any store.
  - req_ready = 0. Next state: IDLE.
- resp_rdata holds its value after RESP until the next RESP.
- Memory-side rules:
  - ReadMem and WriteMem are never high in the same cycle.
  - Both are 0 in IDLE and RESP.
  - data_addr and DataIn are driven 0 outside ACC states.
- Latency, request accepted at edge N, with L = READ_LATENCY:
  - narrow store: resp at cycle N+2.
  - wide store: resp at N+3.
  - narrow load: resp at N+2+L.
  - wide load: resp at N+3+2L.
- Back-to-back: the next request can be accepted no earlier than the cycle after RESP (IDLE).
- Reset mid-operation:
  - Strobes drop immediately.
  - A wide store interrupted after ACC_LO leaves the low byte written and the high byte unchanged.
  - No resp_valid is issued.
- Counters: read-latency wait counter is 2 bits; it resets to 0 on entering each ACC state.

Test Plan:
- Reset held for 2 cycles, then released -> req_ready = 1; all memory strobes 0; resp_valid 0. Assert reset mid-ACC_LO of a store -> WriteMem drops in the same cycle, no resp.
- Narrow store 0x0F at addr 0x00, then narrow load at 0x00 (READ_LATENCY = 0) -> one WriteMem cycle at addr 0x00 with DataIn 0x0F; load resp_rdata = 0x000F, 2 cycles after accept.
- Wide store 0x0604 at 0x0C, then wide load at 0x0C -> writes 0x04 at 0x0C then 0x06 at 0x0D on consecutive cycles; load returns 0x0604 with ReadMem high for exactly 2 cycles.
- Wide store 0xBEEF at 0xFF -> 0xEF written at 0xFF and 0xBE at 0x00 (wrap); wide load at 0xFF returns 0xBEEF.
- READ_LATENCY = 2, narrow load at 0x0C holding 0x06 -> ReadMem and data_addr stable for 3 cycles; resp_valid at accept + 4; resp_rdata = 0x0006.
- req_valid held high continuously across 3 requests -> each accepted only in IDLE; never ReadMem & WriteMem together; exactly one resp_valid pulse per request.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of DataMemory: one byte or little-endian 16-bit
// access per request, with wide accesses split into two byte accesses.
module mem_access_unit #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_wide,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                resp_valid,
  output logic [2*DATA_W-1:0] resp_rdata,
  output logic                ReadMem,
  output logic                WriteMem,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W-1:0]   DataIn,
  input  logic [DATA_W-1:0]   DataOut
);

  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, RESP} state_e;

  localparam logic [1:0] LAT_W = 2'(READ_LATENCY);

  state_e              state_q;
  logic                write_q;
  logic                wide_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2*DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0]   lo_q;
  logic [1:0]          wait_q;

  logic                req_ready_q;
  logic                resp_valid_q;
  logic [2*DATA_W-1:0] resp_rdata_q;
  logic                read_mem_q;
  logic                write_mem_q;
  logic [ADDR_W-1:0]   data_addr_q;
  logic [DATA_W-1:0]   data_in_q;

  logic                acc_done_d;
  logic [ADDR_W-1:0]   hi_addr_d;

  // A store byte completes in one cycle; a load byte waits until the wait
  // counter reaches the read latency, then DataOut is sampled on that edge.
  always_comb begin
    acc_done_d = write_q || (wait_q == LAT_W);
    hi_addr_d  = addr_q + ADDR_W'(1);
  end

  // NOTE: all state, outputs included, uses non-blocking assignments so every
  // register updates from the pre-edge values; the async reset clears the
  // strobes immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      wide_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
      wait_q       <= 2'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      read_mem_q   <= 1'b0;
      write_mem_q  <= 1'b0;
      data_addr_q  <= '0;
      data_in_q    <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q     <= ACC_LO;
            write_q     <= req_write;
            wide_q      <= req_wide;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            wait_q      <= 2'd0;
            req_ready_q <= 1'b0;
            read_mem_q  <= !req_write;
            write_mem_q <= req_write;
            data_addr_q <= req_addr;
            data_in_q   <= req_write ? req_wdata[DATA_W-1:0] : '0;
          end
        end
        ACC_LO: begin
          if (acc_done_d) begin
            lo_q   <= DataOut;
            wait_q <= 2'd0;
            if (wide_q) begin
              state_q     <= ACC_HI;
              data_addr_q <= hi_addr_d;
              data_in_q   <= write_q ? wdata_q[2*DATA_W-1:DATA_W] : '0;
            end else begin
              state_q      <= RESP;
              read_mem_q   <= 1'b0;
              write_mem_q  <= 1'b0;
              data_addr_q  <= '0;
              data_in_q    <= '0;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= write_q ? '0 : {{DATA_W{1'b0}}, DataOut};
            end
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        ACC_HI: begin
          if (acc_done_d) begin
            state_q      <= RESP;
            wait_q       <= 2'd0;
            read_mem_q   <= 1'b0;
            write_mem_q  <= 1'b0;
            data_addr_q  <= '0;
            data_in_q    <= '0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= write_q ? '0 : {DataOut, lo_q};
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign ReadMem    = read_mem_q;
  assign WriteMem   = write_mem_q;
  assign data_addr  = data_addr_q;
  assign DataIn     = data_in_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a zero-latency instance driven from a
// vector table plus corner sequences, and a READ_LATENCY=2 instance.
module tb_mem_access_unit;

  typedef struct {
    logic        write;
    logic        wide;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance with READ_LATENCY = 0
  logic        req_valid = 1'b0, req_write = 1'b0, req_wide = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, resp_valid, ReadMem, WriteMem;
  logic [15:0] resp_rdata;
  logic [7:0]  data_addr, DataIn, DataOut;
  logic [7:0]  mem [256];

  // Instance with READ_LATENCY = 2
  logic        req_valid2 = 1'b0;
  logic [7:0]  req_addr2 = '0;
  logic        req_ready2, resp_valid2, ReadMem2, WriteMem2;
  logic [15:0] resp_rdata2;
  logic [7:0]  data_addr2, DataIn2, DataOut2;
  logic [7:0]  mem2 [256];

  mem_access_unit #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ReadMem(ReadMem), .WriteMem(WriteMem), .data_addr(data_addr),
    .DataIn(DataIn), .DataOut(DataOut)
  );

  mem_access_unit #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_write(1'b0),
    .req_wide(1'b0), .req_addr(req_addr2), .req_wdata(16'h0000),
    .resp_valid(resp_valid2), .resp_rdata(resp_rdata2),
    .ReadMem(ReadMem2), .WriteMem(WriteMem2), .data_addr(data_addr2),
    .DataIn(DataIn2), .DataOut(DataOut2)
  );

  // Byte-wide memory models: synchronous write, combinational read.
  always @(posedge clk) if (WriteMem) mem[data_addr] <= DataIn;
  always @(posedge clk) if (WriteMem2) mem2[data_addr2] <= DataIn2;
  assign DataOut  = mem[data_addr];
  assign DataOut2 = mem2[data_addr2];

  int n_cmp = 0;
  int n_err = 0;
  int overlap_cnt = 0;
  int idle_drive_cnt = 0;

  always @(negedge clk) begin
    if (ReadMem && WriteMem) overlap_cnt++;
    if (ReadMem2 && WriteMem2) overlap_cnt++;
    if (!ReadMem && !WriteMem && (data_addr != 8'h00 || DataIn != 8'h00)) idle_drive_cnt++;
    if (!ReadMem2 && !WriteMem2 && (data_addr2 != 8'h00 || DataIn2 != 8'h00)) idle_drive_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v, input string tag);
    int n;
    int rd_n;
    int wr_n;
    int lat;
    bit got;
    logic [7:0] wa [2];
    logic [7:0] wd [2];
    logic [7:0] addr_hi;
    addr_hi = v.addr + 8'd1;
    wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
    @(negedge clk);
    req_write = v.write;
    req_wide  = v.wide;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check({tag, "_accept"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    rd_n = 0; wr_n = 0; lat = 0; got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (ReadMem) rd_n++;
      if (WriteMem) begin
        if (wr_n < 2) begin
          wa[wr_n] = data_addr;
          wd[wr_n] = DataIn;
        end
        wr_n++;
      end
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
    check({tag, "_rdata"}, {16'h0, resp_rdata}, {16'h0, v.exp_rdata});
    if (v.write) begin
      check({tag, "_wr_cycles"}, 32'(wr_n), v.wide ? 32'd2 : 32'd1);
      check({tag, "_rd_cycles"}, 32'(rd_n), 32'd0);
      check({tag, "_wr_addr0"}, {24'h0, wa[0]}, {24'h0, v.addr});
      check({tag, "_wr_data0"}, {24'h0, wd[0]}, {24'h0, v.wdata[7:0]});
      if (v.wide) begin
        check({tag, "_wr_addr1"}, {24'h0, wa[1]}, {24'h0, addr_hi});
        check({tag, "_wr_data1"}, {24'h0, wd[1]}, {24'h0, v.wdata[15:8]});
      end
    end else begin
      check({tag, "_rd_cycles"}, 32'(rd_n), v.wide ? 32'd2 : 32'd1);
      check({tag, "_wr_cycles"}, 32'(wr_n), 32'd0);
    end
    // One cycle later: back in IDLE, pulse gone, read data held.
    @(negedge clk);
    check({tag, "_pulse_end"}, {31'h0, resp_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'h0, req_ready}, 32'd1);
    check({tag, "_rdata_hold"}, {16'h0, resp_rdata}, {16'h0, v.exp_rdata});
  endtask

  vec_t vecs [10];
  vec_t cont [3];

  initial begin
    int acc;
    int resp;
    int idx;
    int rd_n;
    int unstable;
    int lat;

    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'h00;
      mem2[i] = 8'h00;
    end
    mem2[8'h0C] = 8'h06;

    //           write wide  addr   wdata     exp_rdata lat
    vecs[0] = '{1'b1, 1'b0, 8'h00, 16'h000F, 16'h0000, 2};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 16'h0000, 16'h000F, 2};
    vecs[2] = '{1'b1, 1'b1, 8'h0C, 16'h0604, 16'h0000, 3};
    vecs[3] = '{1'b0, 1'b1, 8'h0C, 16'h0000, 16'h0604, 3};
    vecs[4] = '{1'b1, 1'b1, 8'hFF, 16'hBEEF, 16'h0000, 3};
    vecs[5] = '{1'b0, 1'b1, 8'hFF, 16'h0000, 16'hBEEF, 3};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 16'h0000, 16'h00BE, 2};
    vecs[7] = '{1'b1, 1'b0, 8'h10, 16'h12AB, 16'h0000, 2};
    vecs[8] = '{1'b0, 1'b1, 8'h10, 16'h0000, 16'h00AB, 3};
    vecs[9] = '{1'b0, 1'b0, 8'h0D, 16'h0000, 16'h0006, 2};

    cont[0] = '{1'b1, 1'b0, 8'h20, 16'h0055, 16'h0000, 2};
    cont[1] = '{1'b1, 1'b0, 8'h21, 16'h0066, 16'h0000, 2};
    cont[2] = '{1'b0, 1'b1, 8'h20, 16'h0000, 16'h6655, 3};

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_ready", {31'h0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    check("rst_strobes", {30'h0, ReadMem, WriteMem}, 32'd0);
    check("rst_addr_din", {16'h0, data_addr, DataIn}, 32'd0);
    check("rst_rdata", {16'h0, resp_rdata}, 32'd0);

    for (int i = 0; i < 10; i++) do_req(vecs[i], $sformatf("vec%0d", i));

    check("wrap_mem_ff", {24'h0, mem[8'hFF]}, 32'h0000_00EF);
    check("wrap_mem_00", {24'h0, mem[8'h00]}, 32'h0000_00BE);
    check("narrow_st_hi_untouched", {24'h0, mem[8'h11]}, 32'h0);

    // req_valid held high across three requests
    idx = 0; acc = 0; resp = 0;
    @(negedge clk);
    req_write = cont[0].write; req_wide = cont[0].wide;
    req_addr  = cont[0].addr;  req_wdata = cont[0].wdata;
    req_valid = 1'b1;
    for (int c = 0; c < 60 && resp < 3; c++) begin
      if (req_valid && req_ready) acc++;
      @(negedge clk);
      if (resp_valid) begin
        resp++;
        if (resp == 3) req_valid = 1'b0;
        else begin
          idx = resp;
          req_write = cont[idx].write; req_wide = cont[idx].wide;
          req_addr  = cont[idx].addr;  req_wdata = cont[idx].wdata;
        end
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (req_valid && req_ready) acc++;
      if (resp_valid) resp++;
    end
    check("cont_accepts", 32'(acc), 32'd3);
    check("cont_resps", 32'(resp), 32'd3);
    check("cont_rdata", {16'h0, resp_rdata}, 32'h0000_6655);

    // Reset during ACC_LO of a narrow store
    @(negedge clk);
    req_write = 1'b1; req_wide = 1'b0; req_addr = 8'h50; req_wdata = 16'h0077;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_lo_we_before", {31'h0, WriteMem}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_lo_we_drop", {31'h0, WriteMem}, 32'd0);
    check("rst_lo_ready", {31'h0, req_ready}, 32'd1);
    check("rst_lo_addr", {24'h0, data_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    resp = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) resp++;
    end
    check("rst_lo_no_resp", 32'(resp), 32'd0);
    check("rst_lo_mem", {24'h0, mem[8'h50]}, 32'd0);

    // Reset during ACC_HI of a wide store: low byte lands, high byte does not
    @(negedge clk);
    req_write = 1'b1; req_wide = 1'b1; req_addr = 8'h40; req_wdata = 16'hA1B2;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_hi_we_before", {31'h0, WriteMem}, 32'd1);
    check("rst_hi_addr_before", {24'h0, data_addr}, 32'h41);
    reset = 1'b1;
    #1;
    check("rst_hi_we_drop", {31'h0, WriteMem}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    resp = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) resp++;
    end
    check("rst_hi_no_resp", 32'(resp), 32'd0);
    check("rst_hi_lo_written", {24'h0, mem[8'h40]}, 32'hB2);
    check("rst_hi_hi_unchanged", {24'h0, mem[8'h41]}, 32'h00);

    // READ_LATENCY = 2 narrow load
    @(negedge clk);
    req_addr2 = 8'h0C;
    req_valid2 = 1'b1;
    check("rl2_ready", {31'h0, req_ready2}, 32'd1);
    rd_n = 0; unstable = 0; lat = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(negedge clk);
      req_valid2 = 1'b0;
      if (ReadMem2) begin
        rd_n++;
        if (data_addr2 != 8'h0C) unstable++;
      end
      if (resp_valid2) lat = c;
    end
    check("rl2_rd_cycles", 32'(rd_n), 32'd3);
    check("rl2_addr_stable", 32'(unstable), 32'd0);
    check("rl2_lat", 32'(lat), 32'd4);
    check("rl2_rdata", {16'h0, resp_rdata2}, 32'h0000_0006);

    check("no_rd_wr_overlap", 32'(overlap_cnt), 32'd0);
    check("no_drive_outside_acc", 32'(idle_drive_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
